// File: rtl/rhs_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rhs_seq_pkg
//  Purpose  : Shared types and constants for the RHS command sequencer:
//             sequencer state encoding, RHS opcode constants, the RHS
//             command word layout and default sizing.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package rhs_seq_pkg;

    localparam int DEFAULT_DEPTH   = 64;
    localparam int DEFAULT_TIMEOUT = 1023;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_WAIT_IDLE = 3'd4,
        ST_NEXT      = 3'd5
    } seq_state_e;

    // Opcode field occupies bits [31:30] of an RHS command word.
    localparam logic [1:0] RHS_CMD_CONVERT = 2'b00;
    localparam logic [1:0] RHS_CMD_WRITE   = 2'b10;
    localparam logic [1:0] RHS_CMD_READ    = 2'b11;

    typedef struct packed {
        logic [1:0]  opcode;
        logic [5:0]  flags;
        logic [7:0]  chan_reg;
        logic [15:0] data;
    } rhs_cmd_t;

    function automatic logic [31:0] rhs_cmd_pack(
        input logic [1:0]  opcode,
        input logic [7:0]  chan_reg,
        input logic [15:0] data
    );
        rhs_cmd_t c;
        c.opcode   = opcode;
        c.flags    = '0;
        c.chan_reg = chan_reg;
        c.data     = data;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rhs_cmd_table.sv
`default_nettype none
// ============================================================================
//  Module   : rhs_cmd_table
//  Purpose  : DEPTH x 32 simple dual-port synchronous RAM holding the RHS
//             command words walked by the sequencer.
//  Ports    : clk                         - clock
//             wr_en / wr_addr / wr_data   - configuration write port
//             rd_en / rd_addr / rd_data   - sequencer read port, data valid
//                                           one cycle after rd_en
//  Revision : 1.0 - initial release
// ============================================================================
module rhs_cmd_table #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    // No reset: table contents survive a sequencer reset.
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rhs_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rhs_cmd_sequencer
//  Purpose  : Frame-level scheduler for the RHS SPI master. On each accepted
//             frame_tick it walks command slots 0..seq_last, handshakes each
//             word through the master (start / done) and returns every MISO
//             word as a tagged result beat.
//  Ports    : clk, rstn (sync, active-low)
//             enable, frame_tick, seq_last      - frame control
//             cfg_we, cfg_addr, cfg_data        - command table write port
//             cfg_reject                        - write dropped (not idle)
//             spi_start, spi_cmd                - to SPI master
//             spi_done, spi_rdata               - from SPI master
//             res_valid, res_data, res_slot,
//             res_frame                         - result beat
//             busy, overrun, timeout            - status (last two sticky)
//             sticky_clr                        - clears sticky status
//  Revision : 1.0 - initial release
// ============================================================================
module rhs_cmd_sequencer
    import rhs_seq_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              frame_tick,
    input  logic [ADDR_W-1:0] seq_last,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [31:0]       cfg_data,
    output logic              cfg_reject,
    output logic              spi_start,
    output logic [31:0]       spi_cmd,
    input  logic              spi_done,
    input  logic [31:0]       spi_rdata,
    output logic              res_valid,
    output logic [31:0]       res_data,
    output logic [ADDR_W-1:0] res_slot,
    output logic [15:0]       res_frame,
    output logic              busy,
    output logic              overrun,
    output logic              timeout,
    input  logic              sticky_clr
);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_ARM       = ST_ARM;
    localparam logic [2:0] S_ISSUE     = ST_ISSUE;
    localparam logic [2:0] S_WAIT_DONE = ST_WAIT_DONE;
    localparam logic [2:0] S_WAIT_IDLE = ST_WAIT_IDLE;
    localparam logic [2:0] S_NEXT      = ST_NEXT;

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    // Counter starts at 0 on the first WAIT_DONE cycle, so the abort fires
    // on the cycle that would bring it to TIMEOUT.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] slot;
    logic [ADDR_W-1:0] last_q;
    logic [15:0]       frame_cnt;
    logic [TMO_W-1:0]  tmo_cnt;

    logic              frame_start;
    logic              tbl_wr_en;
    logic              tbl_rd_en;
    logic [ADDR_W-1:0] tbl_rd_addr;
    logic [31:0]       tbl_rd_data;

    assign frame_start = (state == S_IDLE) && frame_tick && enable;
    assign tbl_wr_en   = cfg_we && (state == S_IDLE);
    assign busy        = (state != S_IDLE);

    // Reads are launched one cycle ahead of ARM: slot 0 from IDLE, slot+1
    // from NEXT, so ARM always sees the word for the current slot.
    always_comb begin
        tbl_rd_en   = frame_start || (state == S_NEXT);
        tbl_rd_addr = (state == S_NEXT) ? slot + ADDR_W'(1) : '0;
    end

    rhs_cmd_table #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_table (
        .clk     (clk),
        .wr_en   (tbl_wr_en),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_en   (tbl_rd_en),
        .rd_addr (tbl_rd_addr),
        .rd_data (tbl_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            slot       <= '0;
            last_q     <= '0;
            frame_cnt  <= '0;
            tmo_cnt    <= '0;
            spi_start  <= 1'b0;
            spi_cmd    <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_slot   <= '0;
            res_frame  <= '0;
            cfg_reject <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            spi_start  <= 1'b0;
            res_valid  <= 1'b0;
            cfg_reject <= cfg_we && (state != S_IDLE);

            // Clear first so that a coincident set below takes priority.
            if (sticky_clr) begin
                overrun <= 1'b0;
                timeout <= 1'b0;
            end
            if (frame_tick && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        last_q <= seq_last;
                        slot   <= '0;
                        state  <= S_ARM;
                    end
                end
                S_ARM: begin
                    spi_cmd   <= tbl_rd_data;
                    spi_start <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (spi_done) begin
                        res_valid <= 1'b1;
                        res_data  <= spi_rdata;
                        res_slot  <= slot;
                        res_frame <= frame_cnt;
                        state     <= S_WAIT_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    // done low means the master is back in READY.
                    if (!spi_done) begin
                        if (slot == last_q) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    slot  <= slot + ADDR_W'(1);
                    state <= S_ARM;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/rhs_cmd_sequencer.md
# rhs_cmd_sequencer

Frame-level command scheduler for the RHS stimulation/recording SPI master. On each `frame_tick`, it walks a programmable table of 32-bit RHS command words. For each word it drives the master's start/done handshake and returns every 32-bit MISO response as a tagged result beat. It sits between the host-side configuration/acquisition logic and the single SPI master instance, and it is the only driver of that master's `start` and `data_in`.

## Interface
Parameters:
- `DEPTH`, 64: command table entries. Must be a power of two, ≤256.
- `ADDR_W`, $clog2(DEPTH): slot index width.
- `TIMEOUT`, 1023: maximum clk cycles in WAIT_DONE before the frame is aborted.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: reset, synchronous, active-low.
- `enable` in 1: gates acceptance of `frame_tick`.
- `frame_tick` in 1: single-cycle frame request.
- `seq_last` in ADDR_W: index of the last slot in a frame. Sampled at frame start.
- `cfg_we` in 1: command table write strobe.
- `cfg_addr` in ADDR_W: table write address.
- `cfg_data` in 32: table write data.
- `cfg_reject` out 1: one-cycle pulse when a write is dropped because the sequencer is not IDLE.
- `spi_start` out 1: start pulse to the SPI master.
- `spi_cmd` out 32: command word to the master's `data_in`.
- `spi_done` in 1: master done level.
- `spi_rdata` in 32: master's `data_out`.
- `res_valid` out 1: one-cycle result strobe. There is no backpressure.
- `res_data` out 32: captured MISO word.
- `res_slot` out ADDR_W: slot index that issued the command.
- `res_frame` out 16: frame counter value.
- `busy` out 1: high whenever the state is not IDLE.
- `overrun` out 1: sticky. Set by a tick arriving while not IDLE.
- `timeout` out 1: sticky. Set on WAIT_DONE expiry.
- `sticky_clr` in 1: clears `overrun` and `timeout`.

## Operation
- States: IDLE, ARM, ISSUE, WAIT_DONE, WAIT_IDLE, NEXT.
- IDLE:
  - `frame_tick` & `enable` latches `seq_last` into `last_q`, sets slot=0, issues a table read, and moves to ARM.
  - `cfg_we` writes `cmd_table[cfg_addr]`.
- ARM: the table read completes (synchronous RAM, 1-cycle latency). The word is registered into `spi_cmd`. Go to ISSUE.
- ISSUE: `spi_start`=1 for exactly this cycle. Go to WAIT_DONE.
- WAIT_DONE:
  - The timeout counter increments each cycle.
  - On `spi_done`=1: capture `spi_rdata` and pulse `res_valid` with `res_slot`=slot and `res_frame`=frame_cnt, then go to WAIT_IDLE.
  - When the counter reaches TIMEOUT: set `timeout`, skip the result, and go to IDLE. `frame_cnt` is not incremented.
- WAIT_IDLE: wait for `spi_done`=0, which means the master is back in READY. Then:
  - if slot==`last_q`: `frame_cnt`+=1 (16-bit wrap) and go to IDLE;
  - else go to NEXT.
- NEXT: slot+=1, issue a table read, go to ARM.
- `spi_cmd` holds its value from ARM until the next ARM. It is never changed while the master is busy.
- `frame_tick` in any non-IDLE state: set `overrun`; the tick is discarded, not queued.
- Deasserting `enable` mid-frame does not abort; the current frame completes.
- `cfg_we` in any non-IDLE state: the write is dropped and `cfg_reject` pulses.
- `seq_last` changes mid-frame are ignored because the value is latched at frame start.
- `sticky_clr` coincident with a set event: the set wins.
- Reset (including mid-frame) forces:
  - state IDLE; `spi_start`, `res_valid`, `cfg_reject`, `busy`, `overrun`, `timeout` = 0;
  - `spi_cmd`, `res_data`, `res_slot`, `res_frame`, slot, `frame_cnt` = 0;
  - table contents are not cleared.
- When the master's `done` falls, the master's next READY cycle accepts `start`.

## Timing
- Tick at cycle t in IDLE: ARM at t+1, `spi_start` at t+2.
- `spi_done` rises at cycle d: `res_valid`/`res_data` valid at d+1, registered.
- `spi_done` falls at cycle f: NEXT at f+1, ARM at f+2, next `spi_start` at f+3.
- Per-command overhead beyond the master's own transaction: 4 clk.
- `busy` rises at t+1. It falls the cycle after WAIT_IDLE for the last slot, or the cycle after a timeout.
- A write at cycle w is readable by a frame starting at w+1 or later.

## Structure
- Package `rhs_seq_pkg`:
  - state enum;
  - `RHS_CMD_CONVERT`/`READ`/`WRITE` opcode constants and a `rhs_cmd_t` packed struct (opcode, flags, channel/register, data);
  - default `DEPTH`/`TIMEOUT`.
- Sub-module `rhs_cmd_table`: DEPTH×32 simple dual-port synchronous RAM. Write port is cfg; read port is the sequencer with 1-cycle read latency.
- The FSM, counters and sticky flags live in the top module.

## Test plan
- Load slots 0..3 = 32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000; `seq_last`=3; one tick against an SPI master model that echoes ~cmd.
  - Required: 4 `res_valid` beats, slots 0..3, data ~cmd, `res_frame`=0.
  - Required: `frame_cnt`=1 afterwards and `busy` low.
- Tick at cycle t:
  - Required: `spi_start` exactly at t+2, and high for 1 cycle.
  - After `done` falls at cycle f: next `spi_start` at f+3.
- Second tick during a frame with `seq_last`=3:
  - Required: `overrun`=1 and still only 4 results.
  - `sticky_clr` clears `overrun`.
  - `cfg_we` during the frame pulses `cfg_reject` and leaves the table unchanged.
- Master model never raises done:
  - Required: `timeout`=1 after 1023 cycles in WAIT_DONE, state IDLE, no `res_valid`, and `frame_cnt` unchanged.
- `rstn` low during slot 2 of a frame:
  - Required: all outputs at reset values.
  - A subsequent tick replays from slot 0 with the preserved table.
- Preload `frame_cnt` 0xFFFF via 65535 one-slot frames (`seq_last`=0), then run one more frame:
  - Required: that frame's result has `res_frame`=0xFFFF, and the following frame's result has `res_frame`=0x0000.
